fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage core. It sits directly upstream of the ID stage, whose hazard detection output drives this block's freeze input. It owns the PC and issues one request at a time to a variable-latency instruction memory. It parks a returning word in a one-entry hold buffer while the pipeline is frozen, and discards in-flight fetches on a taken branch.

Parameters:
ADDR_W, 32, PC / instruction address width
INSTR_W, 32, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
freeze  input  1  stall request (hazard_detected from ID); hold PC and IF/ID
branch_taken  input  1  redirect and flush request from EXE
branch_addr  input  ADDR_W  redirect target, valid when branch_taken=1
imem_req  output  1  single-cycle fetch request pulse
imem_addr  output  ADDR_W  fetch address, valid when imem_req=1
imem_valid  input  1  one pulse per request, at least 1 cycle after imem_req
imem_rdata  input  INSTR_W  instruction word, valid when imem_valid=1
id_pc  output  ADDR_W  IF/ID register: fetch address + 4
id_instr  output  INSTR_W  IF/ID register: instruction
id_valid  output  1  IF/ID register: 1 = real instruction, 0 = bubble

Behaviour:
- Reset: applies while rst=1 at a clock edge.
  - pc=RESET_PC, state=S_REQ, buffer and discard flag cleared.
  - id_pc=0, id_instr=0, id_valid=0.
  - imem_req=0 while rst=1.
  - rst overrides all other inputs, including mid-fetch. A stale imem_valid arriving after reset, before the first new request, is ignored.
- State S_REQ:
  - imem_req = ~branch_taken; imem_addr = pc.
  - Next state is S_WAIT, or stays S_REQ when branch_taken=1.
  - Fetch issues regardless of freeze (prefetch).
- State S_WAIT, no imem_valid: stay in S_WAIT.
- State S_WAIT, imem_valid=1:
  - discard flag set: drop data, pc<=redirect_pc, clear flag, go to S_REQ.
  - freeze=1: buf<=imem_rdata, go to S_HOLD.
  - otherwise: IF/ID<={pc+4, imem_rdata, 1}, pc<=pc+4, go to S_REQ.
- State S_HOLD:
  - Hold while freeze=1.
  - On freeze=0: IF/ID<={pc+4, buf, 1}, pc<=pc+4, go to S_REQ.
- IF/ID update on cycles with no new instruction loaded:
  - freeze=1: hold all three fields.
  - freeze=0: id_valid<=0 and id_instr<=0 (bubble); id_pc may hold.
- branch_taken has priority over freeze and over data return:
  - IF/ID flushed: id_valid<=0, id_instr<=0.
  - S_REQ or S_HOLD: pc<=branch_addr, buffer dropped, go to S_REQ.
  - S_WAIT with imem_valid in the same cycle: data dropped, pc<=branch_addr, go to S_REQ.
  - S_WAIT without imem_valid: discard<=1, redirect_pc<=branch_addr. A second branch while discard is set overwrites redirect_pc.
- Latency: an instruction appears in IF/ID on the edge where imem_valid is sampled. Back-to-back throughput at memory latency 1 is one instruction per 2 cycles.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W; there is no alignment checking.
- At most one outstanding request; imem_req is never asserted while in S_WAIT or S_HOLD.

Test Plan:
- Reset then run, memory latency 1, RESET_PC=0 -> imem_addr sequence 0,4,8. IF/ID receives id_pc=4,8,12 with matching words, id_valid pulsing every 2nd cycle with bubbles between.
- Latency 3 memory, word 0xE3A01005 at 0x0 -> imem_req once at 0x0 with no re-request for 3 cycles. id_instr=0xE3A01005, id_pc=4, id_valid=1 on the return edge.
- freeze=1 for 4 cycles spanning data return at 0x8 -> IF/ID unchanged while frozen, word held in buffer. On release, id_pc=0xC with buffered word, next imem_addr=0xC.
- branch_taken=1, branch_addr=0x40 while in S_WAIT for 0x10, data arrives 2 cycles later -> that data never reaches IF/ID. Next imem_addr=0x40, id_valid=0 on the branch edge.
- branch_taken and freeze both 1 in S_HOLD -> buffer dropped, id_valid=0, next imem_req at branch_addr.
- rst=1 in S_WAIT, then stale imem_valid one cycle after release -> stale data ignored. First imem_addr=RESET_PC, all IF/ID outputs 0 until the first valid return.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned INSTR_W = 32
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_valid;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with one outstanding imem request, a one-entry hold buffer
// for returns during freeze, and the IF/ID pipeline register.
module fetch_stage #(
   parameter int unsigned          ADDR_W   = 32,
   parameter int unsigned          INSTR_W  = 32,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                freeze,
   input  logic                branch_taken,
   input  logic [ADDR_W-1:0]   branch_addr,
   fetch_stage_if.master       imem,
   output logic [ADDR_W-1:0]   id_pc,
   output logic [INSTR_W-1:0]  id_instr,
   output logic                id_valid
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   redirect_q, redirect_d;
   logic                discard_q, discard_d;
   logic [INSTR_W-1:0]  hold_q, hold_d;
   logic [ADDR_W-1:0]   id_pc_q, id_pc_d;
   logic [INSTR_W-1:0]  id_instr_q, id_instr_d;
   logic                id_valid_q, id_valid_d;
   logic                req_raw;
   logic [ADDR_W-1:0]   pc_plus4;

   assign pc_plus4       = pc_q + ADDR_W'(4);
   assign imem.imem_req  = req_raw & ~rst;
   assign imem.imem_addr = pc_q;
   assign id_pc          = id_pc_q;
   assign id_instr       = id_instr_q;
   assign id_valid       = id_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         redirect_q <= '0;
         discard_q  <= 1'b0;
         hold_q     <= '0;
         id_pc_q    <= '0;
         id_instr_q <= '0;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         redirect_q <= redirect_d;
         discard_q  <= discard_d;
         hold_q     <= hold_d;
         id_pc_q    <= id_pc_d;
         id_instr_q <= id_instr_d;
         id_valid_q <= id_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      redirect_d = redirect_q;
      discard_d  = discard_q;
      hold_d     = hold_q;
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
      req_raw    = 1'b0;

      // No new instruction: freeze holds IF/ID, otherwise insert a bubble.
      // A taken branch flushes regardless of freeze.
      if (branch_taken || !freeze) begin
         id_valid_d = 1'b0;
         id_instr_d = '0;
      end

      unique case (state_q)
         S_REQ: begin
            if (branch_taken) begin
               pc_d = branch_addr;
            end else begin
               req_raw = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (branch_taken) begin
               if (imem.imem_valid) begin
                  pc_d      = branch_addr;
                  discard_d = 1'b0;
                  state_d   = S_REQ;
               end else begin
                  // Request still in flight: remember where to go once it lands.
                  discard_d  = 1'b1;
                  redirect_d = branch_addr;
               end
            end else if (imem.imem_valid) begin
               if (discard_q) begin
                  pc_d      = redirect_q;
                  discard_d = 1'b0;
                  state_d   = S_REQ;
               end else if (freeze) begin
                  hold_d  = imem.imem_rdata;
                  state_d = S_HOLD;
               end else begin
                  id_pc_d    = pc_plus4;
                  id_instr_d = imem.imem_rdata;
                  id_valid_d = 1'b1;
                  pc_d       = pc_plus4;
                  state_d    = S_REQ;
               end
            end
         end
         S_HOLD: begin
            if (branch_taken) begin
               pc_d    = branch_addr;
               hold_d  = '0;
               state_d = S_REQ;
            end else if (!freeze) begin
               id_pc_d    = pc_plus4;
               id_instr_d = hold_q;
               id_valid_d = 1'b1;
               pc_d       = pc_plus4;
               state_d    = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a variable-latency imem responder.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;

   int          n_checks = 0;
   int          n_pass   = 0;

   int          lat = 1;
   logic        pend = 1'b0;
   int          cnt = 0;
   logic [31:0] pend_addr = '0;
   logic        req_seen;
   logic [31:0] req_addr;

   fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) mif ();

   fetch_stage #(
      .ADDR_W   (32),
      .INSTR_W  (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem         (mif.master),
      .id_pc        (id_pc),
      .id_instr     (id_instr),
      .id_valid     (id_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'hE3A0_1005;
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // One clock cycle: memory response, request capture, edge, settle at negedge.
   task automatic cyc();
      mif.imem_valid = 1'b0;
      if (pend) begin
         if (cnt <= 1) begin
            mif.imem_valid = 1'b1;
            mif.imem_rdata = mem_word(pend_addr);
            pend = 1'b0;
         end else begin
            cnt--;
         end
      end
      #1;
      req_seen = mif.imem_req;
      req_addr = mif.imem_addr;
      if (req_seen) begin
         pend      = 1'b1;
         cnt       = lat;
         pend_addr = req_addr;
      end
      @(posedge clk);
      #1;
      @(negedge clk);
   endtask

   task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] ins, input logic v);
      check({tag, ".pc"}, 64'(id_pc), 64'(pc));
      check({tag, ".instr"}, 64'(id_instr), 64'(ins));
      check({tag, ".valid"}, 64'(id_valid), 64'(v));
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
      mif.imem_valid = 1'b0; mif.imem_rdata = '0;
      @(negedge clk);

      // Reset, then latency-1 streaming
      cyc(); check("rst_req", 64'(req_seen), 64'd0);
      cyc();
      check_id("rst_id", 32'h0, 32'h0, 1'b0);
      rst = 1'b0;
      cyc(); check("t1_req0", 64'({req_seen, req_addr}), {31'd0, 1'b1, 32'h0});
      cyc(); check_id("t1_id4", 32'h4, 32'hE3A0_1005, 1'b1);
      check("t1_noreq", 64'(req_seen), 64'd0);
      cyc(); check("t1_req4", 64'({req_seen, req_addr}), {31'd0, 1'b1, 32'h4});
      check_id("t1_bub", 32'h4, 32'h0, 1'b0);
      cyc(); check_id("t1_id8", 32'h8, 32'hC0DE_0004, 1'b1);
      cyc(); check("t1_req8", 64'(req_addr), 64'h8);
      cyc(); check_id("t1_idc", 32'hC, 32'hC0DE_0008, 1'b1);

      // Latency-3 return of 0xE3A01005 at 0x0
      rst = 1'b1; cyc(); rst = 1'b0; lat = 3;
      cyc(); check("t2_req0", 64'({req_seen, req_addr}), {31'd0, 1'b1, 32'h0});
      cyc(); check("t2_noreq1", 64'(req_seen), 64'd0);
      check("t2_bub", 64'(id_valid), 64'd0);
      cyc(); check("t2_noreq2", 64'(req_seen), 64'd0);
      cyc(); check("t2_noreq3", 64'(req_seen), 64'd0);
      check_id("t2_id", 32'h4, 32'hE3A0_1005, 1'b1);

      // Freeze for 4 cycles spanning the return at 0x8
      lat = 1;
      cyc(); cyc(); check_id("t3_pre", 32'h8, 32'hC0DE_0004, 1'b1);
      freeze = 1'b1;
      cyc(); check("t3_prefetch", 64'({req_seen, req_addr}), {31'd0, 1'b1, 32'h8});
      check_id("t3_f1", 32'h8, 32'hC0DE_0004, 1'b1);
      cyc(); check_id("t3_f2", 32'h8, 32'hC0DE_0004, 1'b1);
      cyc(); cyc(); check_id("t3_f4", 32'h8, 32'hC0DE_0004, 1'b1);
      check("t3_noreq", 64'(req_seen), 64'd0);
      freeze = 1'b0;
      cyc(); check_id("t3_rel", 32'hC, 32'hC0DE_0008, 1'b1);
      cyc(); check("t3_reqc", 64'({req_seen, req_addr}), {31'd0, 1'b1, 32'hC});

      // Branch while waiting for 0x10; late data must be discarded
      cyc(); check_id("t4_id10", 32'h10, 32'hC0DE_000C, 1'b1);
      lat = 3; freeze = 1'b1;
      cyc(); check("t4_req10", 64'(req_addr), 64'h10);
      check_id("t4_frz", 32'h10, 32'hC0DE_000C, 1'b1);
      branch_taken = 1'b1; branch_addr = 32'h40;
      cyc(); check("t4_flush.valid", 64'(id_valid), 64'd0);
      check("t4_flush.instr", 64'(id_instr), 64'd0);
      branch_taken = 1'b0; freeze = 1'b0; lat = 1;
      cyc();
      cyc(); check("t4_drop.valid", 64'(id_valid), 64'd0);
      check("t4_drop.noreq", 64'(req_seen), 64'd0);
      cyc(); check("t4_req40", 64'({req_seen, req_addr}), {31'd0, 1'b1, 32'h40});

      // Branch together with freeze while holding 0x40's word
      freeze = 1'b1;
      cyc(); check("t5_hold.valid", 64'(id_valid), 64'd0);
      branch_taken = 1'b1; branch_addr = 32'h80;
      cyc(); check("t5_flush.valid", 64'(id_valid), 64'd0);
      check("t5_flush.noreq", 64'(req_seen), 64'd0);
      branch_taken = 1'b0; freeze = 1'b0;
      cyc(); check("t5_req80", 64'({req_seen, req_addr}), {31'd0, 1'b1, 32'h80});
      cyc(); check_id("t5_id84", 32'h84, 32'hC0DE_0080, 1'b1);

      // Reset during S_WAIT, stale return right after release
      lat = 2;
      cyc(); check("t6_req84", 64'(req_addr), 64'h84);
      rst = 1'b1;
      cyc(); check("t6_rst_noreq", 64'(req_seen), 64'd0);
      rst = 1'b0;
      cyc(); check("t6_req0", 64'({req_seen, req_addr}), {31'd0, 1'b1, 32'h0});
      check_id("t6_stale", 32'h0, 32'h0, 1'b0);
      cyc(); check_id("t6_wait", 32'h0, 32'h0, 1'b0);
      cyc(); check_id("t6_id4", 32'h4, 32'hE3A0_1005, 1'b1);

      // Branch in S_REQ to the top of the address space; pc+4 wraps
      lat = 1; branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
      cyc(); check("t7_noreq", 64'(req_seen), 64'd0);
      branch_taken = 1'b0;
      cyc(); check("t7_req", 64'({req_seen, req_addr}), {31'd0, 1'b1, 32'hFFFF_FFFC});
      cyc(); check_id("t7_wrap", 32'h0, 32'hC0DE_FFFC, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
